// File: rtl/fir_pkg.sv
// ============================================================================
// Module : fir_pkg
// Brief  : Shared constants, sink FSM state type and clog2 helper for the FIR graph.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int FIR_N = 16;

    typedef enum logic [0:0] {
        SINK_COLLECT = 1'b0,
        SINK_DONE    = 1'b1
    } sink_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sink_fifo.sv
// ============================================================================
// Module : fir_sink_fifo
// Brief  : Synchronous FIFO; a push into a full FIFO is accepted when a pop frees a slot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sink_fifo
    import fir_pkg::*;
#(
    parameter int N     = FIR_N,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [N-1:0]           din,
    output logic                   push_ok,
    output logic                   pop_ok,
    output logic [N-1:0]           dout,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          not_empty;

    assign full      = (level == LW'(DEPTH));
    assign not_empty = (level != '0);

    // Pop is judged on the current level, so an empty FIFO never bypasses a write.
    assign pop_ok  = pop & ~clr & not_empty;
    assign push_ok = push & ~clr & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LW'(1);
            end else if (!push_ok && pop_ok) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_result_sink.sv
// ============================================================================
// Module : fir_result_sink
// Brief  : Captures FIR result tokens into a FIFO, counts a frame, serves host pops.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_result_sink
    import fir_pkg::*;
#(
    parameter int N        = FIR_N,
    parameter int DEPTH    = 16,
    parameter int EXPECTED = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   r_in,
    input  logic [N-1:0]           d_in,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [N-1:0]           rd_data,
    output logic [clog2(DEPTH):0]  level,
    output logic [15:0]            count,
    output logic                   done,
    output logic                   ovf
);

    sink_state_t state;
    sink_state_t state_next;
    logic        token;
    logic        push_ok;
    logic        pop_ok;
    logic        count_hit;
    logic [N-1:0] fifo_dout;

    assign token     = en & r_in & (state == SINK_COLLECT);
    assign count_hit = ((count + 16'd1) == 16'(EXPECTED));
    assign done      = (state == SINK_DONE);

    fir_sink_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (token),
        .pop     (rd_req),
        .din     (d_in),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .dout    (fifo_dout),
        .level   (level)
    );

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = SINK_COLLECT;
        end else if ((state == SINK_COLLECT) && push_ok && count_hit) begin
            state_next = SINK_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SINK_COLLECT;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_next;
            if (clr) begin
                rd_valid <= 1'b0;
                count    <= '0;
                ovf      <= 1'b0;
            end else begin
                rd_valid <= pop_ok;
                if (pop_ok) begin
                    rd_data <= fifo_dout;
                end
                if (push_ok) begin
                    count <= count + 16'd1;
                end
                // A collected token is only ever refused when the FIFO is full.
                if (token && !push_ok) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_result_sink.sv
// ============================================================================
// Module : tb_fir_result_sink
// Brief  : Three sink configurations on shared stimulus, checked against a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_result_sink;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        r_in;
    logic [15:0] d_in;
    logic        rd_req;

    logic        rv_a, rv_b, rv_c;
    logic [15:0] rd_a, rd_b, rd_c;
    logic [3:0]  lv_a;
    logic [2:0]  lv_b;
    logic [4:0]  lv_c;
    logic [15:0] cn_a, cn_b, cn_c;
    logic        dn_a, dn_b, dn_c;
    logic        of_a, of_b, of_c;

    fir_result_sink #(.N(16), .DEPTH(8), .EXPECTED(4)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .r_in(r_in), .d_in(d_in),
        .rd_req(rd_req), .rd_valid(rv_a), .rd_data(rd_a), .level(lv_a),
        .count(cn_a), .done(dn_a), .ovf(of_a));

    fir_result_sink #(.N(16), .DEPTH(4), .EXPECTED(64)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .r_in(r_in), .d_in(d_in),
        .rd_req(rd_req), .rd_valid(rv_b), .rd_data(rd_b), .level(lv_b),
        .count(cn_b), .done(dn_b), .ovf(of_b));

    fir_result_sink u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .r_in(r_in), .d_in(d_in),
        .rd_req(rd_req), .rd_valid(rv_c), .rd_data(rd_c), .level(lv_c),
        .count(cn_c), .done(dn_c), .ovf(of_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int dep_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 16;
    endfunction
    function automatic int exp_of(input int k);
        return (k == 0) ? 4 : 64;
    endfunction

    function automatic int act_rv(input int k);
        return (k == 0) ? int'(rv_a) : (k == 1) ? int'(rv_b) : int'(rv_c);
    endfunction
    function automatic int act_rd(input int k);
        return (k == 0) ? int'(rd_a) : (k == 1) ? int'(rd_b) : int'(rd_c);
    endfunction
    function automatic int act_lv(input int k);
        return (k == 0) ? int'(lv_a) : (k == 1) ? int'(lv_b) : int'(lv_c);
    endfunction
    function automatic int act_cn(input int k);
        return (k == 0) ? int'(cn_a) : (k == 1) ? int'(cn_b) : int'(cn_c);
    endfunction
    function automatic int act_dn(input int k);
        return (k == 0) ? int'(dn_a) : (k == 1) ? int'(dn_b) : int'(dn_c);
    endfunction
    function automatic int act_of(input int k);
        return (k == 0) ? int'(of_a) : (k == 1) ? int'(of_b) : int'(of_c);
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got 0x%0h expected 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue plus frame counters per instance.
    typedef logic [15:0] word_q_t[$];
    word_q_t     mq   [NI];
    int          mcnt [NI];
    bit          mdone[NI];
    bit          movf [NI];
    bit          mrdv [NI];
    logic [15:0] mrdd [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mq[k].delete();
            mcnt[k] = 0; mdone[k] = 0; movf[k] = 0; mrdv[k] = 0; mrdd[k] = 16'h0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            if (clr) begin
                mq[k].delete();
                mcnt[k] = 0; mdone[k] = 0; movf[k] = 0; mrdv[k] = 0;
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = rd_req && (mq[k].size() > 0);
                do_push = 0;
                if (en && r_in && !mdone[k]) begin
                    if (mq[k].size() < dep_of(k) || do_pop) do_push = 1;
                    else movf[k] = 1;
                end
                mrdv[k] = do_pop;
                if (do_pop) mrdd[k] = mq[k].pop_front();
                if (do_push) begin
                    mq[k].push_back(d_in);
                    mcnt[k]++;
                    if (mcnt[k] == exp_of(k)) mdone[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < NI; k++) begin
            chk("model_level", k, act_lv(k), mq[k].size());
            chk("model_count", k, act_cn(k), mcnt[k]);
            chk("model_done",  k, act_dn(k), int'(mdone[k]));
            chk("model_ovf",   k, act_of(k), int'(movf[k]));
            chk("model_rdv",   k, act_rv(k), int'(mrdv[k]));
            if (mrdv[k]) chk("model_rdata", k, act_rd(k), int'(mrdd[k]));
        end
    endtask

    task automatic cyc(input bit c, input bit e, input bit r, input logic [15:0] d, input bit rq);
        clr = c; en = e; r_in = r; d_in = d; rd_req = rq;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        bit          c, e, r;
        logic [15:0] d;
        bit          rq;
        int          lvl, cnt;
        bit          dn, rv;
        logic [15:0] rdat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 1, 1, 16'd1,    0, 1, 1, 0, 0, 16'd0};
        tbl[1] = '{0, 1, 1, 16'd2,    0, 2, 2, 0, 0, 16'd0};
        tbl[2] = '{0, 1, 1, 16'd3,    0, 3, 3, 0, 0, 16'd0};
        tbl[3] = '{0, 1, 1, 16'd4,    0, 4, 4, 1, 0, 16'd0};
        tbl[4] = '{0, 0, 0, 16'd0,    1, 3, 4, 1, 1, 16'd1};
        tbl[5] = '{0, 0, 0, 16'd0,    1, 2, 4, 1, 1, 16'd2};
        tbl[6] = '{0, 0, 0, 16'd0,    1, 1, 4, 1, 1, 16'd3};
        tbl[7] = '{0, 0, 0, 16'd0,    1, 0, 4, 1, 1, 16'd4};
        tbl[8] = '{0, 0, 0, 16'd0,    1, 0, 4, 1, 0, 16'd4};
        tbl[9] = '{0, 1, 1, 16'h1234, 0, 0, 4, 1, 0, 16'd4};

        rst = 1'b1; en = 0; clr = 0; r_in = 0; d_in = 0; rd_req = 0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_level", k, act_lv(k), 0);
            chk("reset_count", k, act_cn(k), 0);
            chk("reset_done",  k, act_dn(k), 0);
            chk("reset_ovf",   k, act_of(k), 0);
            chk("reset_rdv",   k, act_rv(k), 0);
            chk("reset_rdata", k, act_rd(k), 0);
        end
        rst = 1'b0;

        // Frame of four on instance A (EXPECTED=4), then drain and DONE gating.
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].c, tbl[i].e, tbl[i].r, tbl[i].d, tbl[i].rq);
            chk("tbl_level", 0, act_lv(0), tbl[i].lvl);
            chk("tbl_count", 0, act_cn(0), tbl[i].cnt);
            chk("tbl_done",  0, act_dn(0), int'(tbl[i].dn));
            chk("tbl_rdv",   0, act_rv(0), int'(tbl[i].rv));
            chk("tbl_rdata", 0, act_rd(0), int'(tbl[i].rdat));
            chk("tbl_ovf",   0, act_of(0), 0);
        end

        // Full + pop on instance B (DEPTH=4): the new word is accepted.
        cyc(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'h21 + 16'(i), 0);
        cyc(0, 1, 1, 16'h00AA, 1);
        chk("fullpop_level", 1, act_lv(1), 4);
        chk("fullpop_ovf",   1, act_of(1), 0);
        chk("fullpop_rdata", 1, act_rd(1), 16'h21);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 16'h0, 1);
            chk("fullpop_drain", 1, act_rd(1), (i == 3) ? 16'hAA : 16'h22 + i);
        end

        // Overflow on instance B: five pushes, only four retained.
        cyc(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 16'h11 + 16'(i), 0);
        chk("ovf_level", 1, act_lv(1), 4);
        chk("ovf_flag",  1, act_of(1), 1);
        chk("ovf_count", 1, act_cn(1), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 16'h0, 1);
            chk("ovf_rdv",   1, act_rv(1), 1);
            chk("ovf_rdata", 1, act_rd(1), 16'h11 + i);
        end
        cyc(0, 0, 0, 16'h0, 1);
        chk("ovf_empty_rdv", 1, act_rv(1), 0);

        // Enable gating on instance C.
        cyc(1, 0, 0, 16'h0, 0);
        cyc(0, 1, 1, 16'h5, 0);
        cyc(0, 1, 1, 16'h6, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 16'h7, 0);
            chk("gate_count", 2, act_cn(2), 2);
            chk("gate_level", 2, act_lv(2), 2);
        end

        // CLR beats a simultaneous push and pop.
        cyc(1, 1, 1, 16'h77, 1);
        for (int k = 0; k < NI; k++) begin
            chk("clr_level", k, act_lv(k), 0);
            chk("clr_count", k, act_cn(k), 0);
            chk("clr_done",  k, act_dn(k), 0);
            chk("clr_rdv",   k, act_rv(k), 0);
        end

        // Asynchronous reset mid-cycle with five words held in instance C.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 16'h40 + 16'(i), 0);
        chk("prerst_level", 2, act_lv(2), 5);
        en = 0; r_in = 0; rd_req = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NI; k++) begin
            chk("arst_level", k, act_lv(k), 0);
            chk("arst_count", k, act_cn(k), 0);
            chk("arst_done",  k, act_dn(k), 0);
            chk("arst_ovf",   k, act_of(k), 0);
            chk("arst_rdata", k, act_rd(k), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 16'h0, 1);
        for (int k = 0; k < NI; k++) chk("arst_pop_rdv", k, act_rv(k), 0);

        // Pointer wrap on instance B: 3*DEPTH push/pop pairs.
        cyc(0, 1, 1, 16'h100, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 1, 16'h101 + 16'(i), 1);
            chk("wrap_rdata", 1, act_rd(1), 16'h100 + i);
            chk("wrap_level", 1, act_lv(1), 1);
        end

        // Randomized traffic, two phases of pop pressure.
        cyc(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) < 2,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) != 0,
                16'($urandom),
                $urandom_range(0, 99) < ((i < 750) ? 35 : 75));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
